// File: rtl/memory_fsm_reader.sv
`default_nettype none
// ============================================================================
// Module   : memory_fsm_reader
// Brief    : Reads LEN words back from a dual-port memory, two per pass, and
//            verifies them against the Fibonacci recurrence mod 2^DATA_W.
// Revision : 1.0 - initial release
// ============================================================================
module memory_fsm_reader #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 16,
  parameter int MEM_W    = 18,
  parameter int LEN      = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic              sel,
  input  logic [MEM_W-1:0]  rd0,
  input  logic [MEM_W-1:0]  rd1,
  output logic [ADDR_W-1:0] addr0,
  output logic [ADDR_W-1:0] addr1,
  output logic              en0,
  output logic              en1,
  output logic              we0,
  output logic              we1,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr,
  output logic              err_port,
  output logic [ADDR_W:0]   checked,
  output logic [DATA_W-1:0] display
);

  localparam int CHK_W = ADDR_W + 1;
  localparam int K_W   = (LEN > 2) ? $clog2(LEN / 2) : 1;
  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [K_W-1:0]   K_LAST   = K_W'(LEN / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              en_q, en_d, busy_q, busy_d;
  logic              done_q, done_d, error_q, error_d;
  logic              err_port_q, err_port_d;
  logic [CHK_W-1:0]  checked_q, checked_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] p2_q, p2_d, p1_q, p1_d;
  logic [DATA_W-1:0] d0_q, d0_d, d1_q, d1_d;
  logic [DATA_W-1:0] w0, w1, e0, e1;
  logic              pair_ok;

  // Only the low DATA_W bits of each memory word take part in checking.
  generate
    if (MEM_W > DATA_W) begin : g_unused_hi
      logic unused_rd_hi;
      assign unused_rd_hi = ^{rd0[MEM_W-1:DATA_W], rd1[MEM_W-1:DATA_W]};
    end
  endgenerate

  assign w0      = rd0[DATA_W-1:0];
  assign w1      = rd1[DATA_W-1:0];
  assign e0      = p2_q + p1_q;
  assign e1      = p1_q + w0;
  assign pair_ok = (k_q == '0) || ((w0 == e0) && (w1 == e1));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= S_IDLE;
      addr0_q    <= '0;
      addr1_q    <= '0;
      err_addr_q <= '0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_port_q <= 1'b0;
      checked_q  <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      p2_q       <= '0;
      p1_q       <= '0;
      d0_q       <= '0;
      d1_q       <= '0;
    end else begin
      state_q    <= state_d;
      addr0_q    <= addr0_d;
      addr1_q    <= addr1_d;
      err_addr_q <= err_addr_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_port_q <= err_port_d;
      checked_q  <= checked_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      p2_q       <= p2_d;
      p1_q       <= p1_d;
      d0_q       <= d0_d;
      d1_q       <= d1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr0_d    = addr0_q;
    addr1_d    = addr1_q;
    err_addr_d = err_addr_q;
    en_d       = en_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    err_port_d = err_port_q;
    checked_d  = checked_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    p2_d       = p2_q;
    p1_d       = p1_q;
    d0_d       = d0_q;
    d1_d       = d1_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_ISSUE;
          k_d        = '0;
          addr0_d    = base;
          addr1_d    = base + ADDR_W'(1);
          en_d       = 1'b1;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_addr_d = '0;
          err_port_d = 1'b0;
          checked_d  = '0;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = CNT_LOAD;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_CHECK: begin
        // Display follows every pair read, including the one that fails.
        d0_d = w0;
        d1_d = w1;
        if (pair_ok) begin
          p2_d      = w0;
          p1_d      = w1;
          checked_d = checked_q + CHK_W'(2);
          if (k_q == K_LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            en_d    = 1'b0;
          end else begin
            state_d = S_ISSUE;
            k_d     = k_q + K_W'(1);
            addr0_d = addr0_q + ADDR_W'(2);
            addr1_d = addr1_q + ADDR_W'(2);
          end
        end else begin
          state_d = S_ERROR;
          error_d = 1'b1;
          busy_d  = 1'b0;
          en_d    = 1'b0;
          if (w0 != e0) begin
            err_addr_d = addr0_q;
            err_port_d = 1'b0;
          end else begin
            err_addr_d = addr1_q;
            err_port_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign addr0    = addr0_q;
  assign addr1    = addr1_q;
  assign en0      = en_q;
  assign en1      = en_q;
  assign we0      = 1'b0;
  assign we1      = 1'b0;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign err_addr = err_addr_q;
  assign err_port = err_port_q;
  assign checked  = checked_q;
  assign display  = sel ? d1_q : d0_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_fsm_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_fsm_reader
// Brief    : Self-checking bench; three reader instances share one memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_fsm_reader;
  localparam int AW = 15;
  localparam int DW = 16;
  localparam int MW = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clr;
  logic [2:0]    start_v;
  logic [AW-1:0] base;
  logic          sel;

  wire [2:0][MW-1:0] rd0_v, rd1_v;
  wire [2:0][AW-1:0] addr0_v, addr1_v, err_addr_v;
  wire [2:0]         en0_v, en1_v, we0_v, we1_v, busy_v, done_v, error_v, err_port_v;
  wire [2:0][AW:0]   checked_v;
  wire [2:0][DW-1:0] display_v;

  int lenv [3] = '{8, 4, 8};
  int rlv  [3] = '{1, 1, 3};

  memory_fsm_reader #(.ADDR_W(AW), .DATA_W(DW), .MEM_W(MW), .LEN(8), .READ_LAT(1)) u_dut_a (
    .clk(clk), .clr(clr), .start(start_v[0]), .base(base), .sel(sel),
    .rd0(rd0_v[0]), .rd1(rd1_v[0]), .addr0(addr0_v[0]), .addr1(addr1_v[0]),
    .en0(en0_v[0]), .en1(en1_v[0]), .we0(we0_v[0]), .we1(we1_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .error(error_v[0]), .err_addr(err_addr_v[0]),
    .err_port(err_port_v[0]), .checked(checked_v[0]), .display(display_v[0]));

  memory_fsm_reader #(.ADDR_W(AW), .DATA_W(DW), .MEM_W(MW), .LEN(4), .READ_LAT(1)) u_dut_b (
    .clk(clk), .clr(clr), .start(start_v[1]), .base(base), .sel(sel),
    .rd0(rd0_v[1]), .rd1(rd1_v[1]), .addr0(addr0_v[1]), .addr1(addr1_v[1]),
    .en0(en0_v[1]), .en1(en1_v[1]), .we0(we0_v[1]), .we1(we1_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .error(error_v[1]), .err_addr(err_addr_v[1]),
    .err_port(err_port_v[1]), .checked(checked_v[1]), .display(display_v[1]));

  memory_fsm_reader #(.ADDR_W(AW), .DATA_W(DW), .MEM_W(MW), .LEN(8), .READ_LAT(3)) u_dut_c (
    .clk(clk), .clr(clr), .start(start_v[2]), .base(base), .sel(sel),
    .rd0(rd0_v[2]), .rd1(rd1_v[2]), .addr0(addr0_v[2]), .addr1(addr1_v[2]),
    .en0(en0_v[2]), .en1(en1_v[2]), .we0(we0_v[2]), .we1(we1_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .error(error_v[2]), .err_addr(err_addr_v[2]),
    .err_port(err_port_v[2]), .checked(checked_v[2]), .display(display_v[2]));

  // Shared memory with per-instance read pipelines (1 or 3 cycles of latency).
  logic [MW-1:0] mem [0:(1<<AW)-1];
  logic [MW-1:0] pp0 [3][3];
  logic [MW-1:0] pp1 [3][3];
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (en0_v[i]) pp0[i][0] <= mem[addr0_v[i]];
      if (en1_v[i]) pp1[i][0] <= mem[addr1_v[i]];
      pp0[i][1] <= pp0[i][0];
      pp0[i][2] <= pp0[i][1];
      pp1[i][1] <= pp1[i][0];
      pp1[i][2] <= pp1[i][1];
    end
  end
  assign rd0_v[0] = pp0[0][0];
  assign rd1_v[0] = pp1[0][0];
  assign rd0_v[1] = pp0[1][0];
  assign rd1_v[1] = pp1[1][0];
  assign rd0_v[2] = pp0[2][2];
  assign rd1_v[2] = pp1[2][2];

  logic we_seen = 1'b0;
  always @(negedge clk) if ((we0_v | we1_v) != 3'b000) we_seen <= 1'b1;

  int tests = 0;
  int fails = 0;
  int got_a0[$];
  int got_a1[$];

  // Writes a Fibonacci run mod 2^16; hi_mode 0: upper bits 0, 1: 2'b11, 2: random.
  task automatic fill_fib(input int b, input int n, input int s0, input int s1, input int hi_mode);
    int f [64];
    logic [1:0] hi;
    f[0] = s0 & 'hFFFF;
    f[1] = s1 & 'hFFFF;
    for (int i = 2; i < n; i++) f[i] = (f[i-2] + f[i-1]) % 65536;
    for (int i = 0; i < n; i++) begin
      hi = (hi_mode == 0) ? 2'b00 : (hi_mode == 1) ? 2'b11 : 2'($urandom);
      mem[(b + i) % 32768] = {hi, 16'(f[i])};
    end
  endtask

  // Reference: walk the words pair by pair and apply the recurrence directly.
  task automatic model(input int inst, input int b, output bit x_err, output int x_addr,
                       output bit x_port, output int x_chk, output int x_cyc,
                       output int x_d0, output int x_d1);
    int w [64];
    int len;
    len = lenv[inst];
    for (int i = 0; i < len; i++) w[i] = int'(mem[(b + i) % 32768][15:0]);
    x_err = 0; x_addr = 0; x_port = 0; x_chk = len;
    x_cyc = (len / 2) * (2 + rlv[inst]);
    x_d0 = 0; x_d1 = 0;
    for (int j = 0; j < len / 2; j++) begin
      x_d0 = w[2*j];
      x_d1 = w[2*j+1];
      if (j > 0) begin
        if (w[2*j] != (w[2*j-2] + w[2*j-1]) % 65536) begin
          x_err = 1; x_port = 0; x_addr = (b + 2*j) % 32768;
        end else if (w[2*j+1] != (w[2*j-1] + w[2*j]) % 65536) begin
          x_err = 1; x_port = 1; x_addr = (b + 2*j + 1) % 32768;
        end
        if (x_err) begin
          x_chk = 2 * j;
          x_cyc = (j + 1) * (2 + rlv[inst]);
          break;
        end
      end
    end
  endtask

  // Starts a run on one instance and returns cycles from the start edge to done/error.
  task automatic run_inst(input int inst, input int b, input bit repulse,
                          output int cyc, output bit en_ok, output bit timeout);
    int per;
    per = 2 + rlv[inst];
    got_a0.delete();
    got_a1.delete();
    base = AW'(b);
    start_v[inst] = 1'b1;
    @(posedge clk); #1;
    start_v[inst] = 1'b0;
    cyc = 0; en_ok = 1'b1; timeout = 1'b0;
    got_a0.push_back(int'(addr0_v[inst]));
    got_a1.push_back(int'(addr1_v[inst]));
    if (!en0_v[inst] || !en1_v[inst] || !busy_v[inst]) en_ok = 1'b0;
    forever begin
      start_v[inst] = (repulse && cyc == 1);
      @(posedge clk); #1;
      cyc++;
      if (done_v[inst] || error_v[inst]) break;
      if (cyc >= 200) begin timeout = 1'b1; break; end
      if (!busy_v[inst]) en_ok = 1'b0;
      if ((cyc % per) != per - 1 && (!en0_v[inst] || !en1_v[inst])) en_ok = 1'b0;
      if (cyc % per == 0) begin
        got_a0.push_back(int'(addr0_v[inst]));
        got_a1.push_back(int'(addr1_v[inst]));
      end
    end
    start_v[inst] = 1'b0;
    if (en0_v[inst] || en1_v[inst] || busy_v[inst]) en_ok = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b0; start_v = '0; base = '0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({addr0_v[i], addr1_v[i], en0_v[i], en1_v[i], busy_v[i], done_v[i], error_v[i],
           err_addr_v[i], err_port_v[i], checked_v[i], display_v[i]} !== '0) begin
        fails++;
        $display("FAIL reset_outputs inst%0d: addr0=%h busy=%b done=%b checked=%0d, all expected 0",
                 i, addr0_v[i], busy_v[i], done_v[i], checked_v[i]);
      end
    end
    clr = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fib_basic();
    int cyc; bit en_ok, to;
    fill_fib(0, 8, 0, 1, 0);
    run_inst(0, 0, 1'b0, cyc, en_ok, to);
    tests++; if (to || cyc != 12) begin fails++; $display("FAIL basic_latency: got %0d cycles expected 12", cyc); end
    tests++; if (done_v[0] !== 1'b1 || error_v[0] !== 1'b0) begin fails++; $display("FAIL basic_status: done=%b error=%b expected 1/0", done_v[0], error_v[0]); end
    tests++; if (checked_v[0] !== 16'd8) begin fails++; $display("FAIL basic_checked: got %0d expected 8", checked_v[0]); end
    tests++; if (!en_ok) begin fails++; $display("FAIL basic_enables: got en/busy profile bad, expected high while running"); end
    tests++;
    if (got_a0.size() != 4 || got_a0[1] != 2 || got_a0[3] != 6 || got_a1[0] != 1 || got_a1[3] != 7) begin
      fails++; $display("FAIL basic_addrs: got %0d issues a0[3]=%0d a1[3]=%0d expected 4,6,7", got_a0.size(), got_a0[3], got_a1[3]);
    end
    sel = 1'b0; #1;
    tests++; if (display_v[0] !== 16'd8) begin fails++; $display("FAIL basic_disp0: got %0d expected 8", display_v[0]); end
    sel = 1'b1; #1;
    tests++; if (display_v[0] !== 16'd13) begin fails++; $display("FAIL basic_disp1: got %0d expected 13", display_v[0]); end
    sel = 1'b0;
  endtask

  task automatic test_bad_word();
    int cyc; bit en_ok, to;
    fill_fib(0, 8, 0, 1, 0);
    mem[5] = 18'd6;
    run_inst(0, 0, 1'b0, cyc, en_ok, to);
    tests++; if (error_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin fails++; $display("FAIL bad_status: error=%b done=%b expected 1/0", error_v[0], done_v[0]); end
    tests++; if (err_addr_v[0] !== 15'd5 || err_port_v[0] !== 1'b1) begin fails++; $display("FAIL bad_where: addr=%0d port=%b expected 5/1", err_addr_v[0], err_port_v[0]); end
    tests++; if (checked_v[0] !== 16'd4) begin fails++; $display("FAIL bad_checked: got %0d expected 4", checked_v[0]); end
    tests++; if (to || cyc != 9) begin fails++; $display("FAIL bad_latency: got %0d cycles expected 9", cyc); end
    sel = 1'b1; #1;
    tests++; if (display_v[0] !== 16'd6) begin fails++; $display("FAIL bad_disp1: got %0d expected 6", display_v[0]); end
    sel = 1'b0;
  endtask

  task automatic test_addr_wrap();
    int cyc; bit en_ok, to;
    mem[15'h7FFE] = 18'd0; mem[15'h7FFF] = 18'd1; mem[0] = 18'd1; mem[1] = 18'd2;
    run_inst(1, 'h7FFE, 1'b0, cyc, en_ok, to);
    tests++;
    if (got_a0.size() != 2 || got_a0[0] != 'h7FFE || got_a0[1] != 0 || got_a1[0] != 'h7FFF || got_a1[1] != 1) begin
      fails++; $display("FAIL wrap_addrs: got a0=%h,%h a1=%h,%h expected 7ffe,0 7fff,1", got_a0[0], got_a0[1], got_a1[0], got_a1[1]);
    end
    tests++; if (done_v[1] !== 1'b1 || to || cyc != 6) begin fails++; $display("FAIL wrap_done: done=%b cycles=%0d expected 1/6", done_v[1], cyc); end
  endtask

  task automatic test_mod_wrap();
    int cyc; bit en_ok, to;
    fill_fib(100, 4, 'hFFFF, 1, 1);
    run_inst(1, 100, 1'b0, cyc, en_ok, to);
    tests++; if (done_v[1] !== 1'b1 || error_v[1] !== 1'b0) begin fails++; $display("FAIL modwrap_status: done=%b error=%b expected 1/0", done_v[1], error_v[1]); end
    tests++; if (checked_v[1] !== 16'd4) begin fails++; $display("FAIL modwrap_checked: got %0d expected 4", checked_v[1]); end
  endtask

  task automatic test_restart_and_abort();
    int cyc; bit en_ok, to;
    fill_fib(0, 8, 0, 1, 0);
    run_inst(0, 0, 1'b1, cyc, en_ok, to);
    tests++; if (to || cyc != 12 || done_v[0] !== 1'b1) begin fails++; $display("FAIL restart_ignored: got %0d cycles done=%b expected 12/1", cyc, done_v[0]); end
    base = '0;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0;
    #1;
    tests++;
    if ({addr0_v[0], addr1_v[0], en0_v[0], en1_v[0], busy_v[0], done_v[0], error_v[0],
         err_addr_v[0], err_port_v[0], checked_v[0], display_v[0]} !== '0) begin
      fails++;
      $display("FAIL abort_clear: addr0=%h en0=%b busy=%b checked=%0d disp=%0d expected all 0",
               addr0_v[0], en0_v[0], busy_v[0], checked_v[0], display_v[0]);
    end
    #2 clr = 1'b1;
    @(posedge clk); #1;
    run_inst(0, 0, 1'b0, cyc, en_ok, to);
    tests++; if (to || cyc != 12 || done_v[0] !== 1'b1 || checked_v[0] !== 16'd8) begin
      fails++; $display("FAIL abort_rerun: cycles=%0d done=%b checked=%0d expected 12/1/8", cyc, done_v[0], checked_v[0]);
    end
  endtask

  task automatic test_lat3();
    int cyc; bit en_ok, to;
    fill_fib(0, 8, 0, 1, 0);
    run_inst(2, 0, 1'b0, cyc, en_ok, to);
    tests++; if (to || cyc != 20 || done_v[2] !== 1'b1) begin fails++; $display("FAIL lat3_latency: got %0d cycles done=%b expected 20/1", cyc, done_v[2]); end
    tests++; if (!en_ok) begin fails++; $display("FAIL lat3_enables: got bad en/busy profile, expected high in ISSUE/WAIT, low in DONE"); end
    tests++; if (we_seen !== 1'b0) begin fails++; $display("FAIL write_enable: got we seen=%b expected 0", we_seen); end
  endtask

  task automatic test_random();
    int cyc, inst, b, x_addr, x_chk, x_cyc, x_d0, x_d1, idx;
    bit en_ok, to, x_err, x_port;
    for (int t = 0; t < 12; t++) begin
      inst = $urandom_range(0, 2);
      b    = $urandom_range(0, 32767);
      fill_fib(b, lenv[inst], $urandom_range(0, 65535), $urandom_range(0, 65535), 2);
      if ($urandom_range(0, 1) == 1) begin
        idx = (b + $urandom_range(0, lenv[inst] - 1)) % 32768;
        mem[idx] = mem[idx] ^ {2'b00, 16'($urandom_range(1, 65535))};
      end
      model(inst, b, x_err, x_addr, x_port, x_chk, x_cyc, x_d0, x_d1);
      run_inst(inst, b, 1'b0, cyc, en_ok, to);
      tests++; if (to || cyc != x_cyc) begin fails++; $display("FAIL rnd%0d_latency: got %0d expected %0d", t, cyc, x_cyc); end
      tests++; if (error_v[inst] !== x_err || done_v[inst] !== !x_err) begin
        fails++; $display("FAIL rnd%0d_status: error=%b done=%b expected error=%b", t, error_v[inst], done_v[inst], x_err);
      end
      tests++; if (int'(checked_v[inst]) != x_chk) begin fails++; $display("FAIL rnd%0d_checked: got %0d expected %0d", t, checked_v[inst], x_chk); end
      tests++; if (int'(err_addr_v[inst]) != x_addr || err_port_v[inst] !== x_port) begin
        fails++; $display("FAIL rnd%0d_where: addr=%h port=%b expected %h/%b", t, err_addr_v[inst], err_port_v[inst], x_addr, x_port);
      end
      sel = 1'b0; #1;
      tests++; if (int'(display_v[inst]) != x_d0) begin fails++; $display("FAIL rnd%0d_disp0: got %h expected %h", t, display_v[inst], x_d0); end
      sel = 1'b1; #1;
      tests++; if (int'(display_v[inst]) != x_d1) begin fails++; $display("FAIL rnd%0d_disp1: got %h expected %h", t, display_v[inst], x_d1); end
      sel = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    test_reset();
    test_fib_basic();
    test_bad_word();
    test_addr_wrap();
    test_mod_wrap();
    test_restart_and_abort();
    test_lat3();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
